uart_8250_rx: RTL and testbench
===============================

# uart_8250_rx

Receive half of the 8250-compatible UART: oversamples the serial input, frames 5–8-bit characters with optional parity, and buffers them with per-character error flags in a receive FIFO. It sits beside the transmit path in the bus-facing UART register block, which drives its divisor/line-control inputs and maps its outputs onto RHR, LSR bits 0–4 and 7, and the IIR receive/timeout sources.

## Interface
- FIFO_DEPTH, 16: receive FIFO entries; a power of two, 4..64.
- OVERSAMPLE, 16: baud ticks per bit; an even number ≥ 4.
- CLK_I  in  1  system clock; the only clock.
- RST_I  in  1  reset, asynchronous and active-low.
- RX_I  in  1  serial input, asynchronous to CLK_I; idle high.
- DIVISOR_I  in  16  CLK_I cycles per baud tick; 0 is treated as 1.
- LCR_I  in  5  [1:0] word length (00=5 … 11=8), [2] stop bits (ignored; one stop bit is checked), [3] parity enable, [4] even parity.
- RD_I  in  1  pop strobe (RHR read); one pop per asserted cycle.
- FIFO_CLR_I  in  1  flush the FIFO (FCR[1]).
- LSR_CLR_I  in  1  clear OE_O (LSR read).
- DAT_O  out  8  head character, zero-extended for <8 bits; 0 when empty.
- DR_O  out  1  FIFO non-empty.
- OE_O  out  1  sticky overrun.
- PE_O, FE_O, BI_O  out  1 each  parity/framing/break flags of the head entry.
- ERR_O  out  1  at least one FIFO entry carries PE, FE or BI.
- TIMEOUT_O  out  1  character-timeout indication.
- LEVEL_O  out  7  current FIFO occupancy.

## Operation
- RX_I passes through a 2-flop synchronizer; both flops reset to 1.
- The tick generator pulses for one CLK_I cycle every max(DIVISOR_I,1) cycles. A DIVISOR_I change takes effect at the next counter reload.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
  - IDLE → START when the synchronized RX is low on a tick. Reset the tick counter.
  - START: after OVERSAMPLE/2 ticks, sample RX. If 0, go to DATA; if 1, treat as a glitch, return to IDLE, and push nothing.
  - DATA: sample every OVERSAMPLE ticks, LSB first, 5+LCR_I[1:0] bits.
  - Then go to PARITY if LCR_I[3] is set, otherwise go to STOP.
  - PARITY: set PE if the received bit ≠ computed parity. Computed parity = XOR of the data bits, inverted for odd.
  - STOP: sample at mid-bit. A sampled 0 sets FE.
  - BI is set when data, parity and stop all sampled 0. BI forces the stored data to 0x00.
  - At the stop sample, push {BI,FE,PE,data}. Go to BRK_WAIT if BI, else go to IDLE immediately, without waiting for the end of the stop bit.
  - BRK_WAIT → IDLE when the synchronized RX is 1.
- LCR_I is sampled once at START→DATA. A mid-frame change does not affect the current frame.
- FIFO, width 11:
  - A push when full discards the new character and sets OE_O.
  - A push and a pop in the same cycle when full succeed: no overrun, level unchanged.
  - A pop when empty is ignored.
- OE_O clears on LSR_CLR_I. A set on the same cycle as the clear wins.
- ERR_O is driven from a counter of errored entries, updated on push, pop and flush.
- FIFO_CLR_I empties the FIFO, zeroes the error count and clears TIMEOUT_O. It does not abort the frame in progress. A same-cycle push is discarded and does not set OE_O.
- TIMEOUT_O sets when DR_O=1 and no push or pop has occurred for 4×(2+data bits+parity)×OVERSAMPLE ticks. It clears on any push, pop or flush.

## Timing
- Reset values: DAT_O=0, DR_O=0, OE_O=0, PE_O=FE_O=BI_O=0, ERR_O=0, TIMEOUT_O=0, LEVEL_O=0. FSM resets to IDLE, all counters to 0.
- Reset asserted mid-frame aborts the frame and clears the FIFO.
- RX_I to the FSM: 2 CLK_I cycles of synchronizer latency.
- The push is registered on the cycle after the stop-sample tick. DR_O, DAT_O and LEVEL_O update on the following edge.
- A pop updates DAT_O, the flags and LEVEL_O on the next edge. Back-to-back pops on consecutive cycles are legal.
- Frame latency, falling start edge to DR_O, at divisor D: ≈ (1+N+P+0.5)×OVERSAMPLE×D + 4 cycles, where N is data bits and P is the parity bit.

## Structure
- The package uart_8250_pkg holds:
  - LCR field indices.
  - Word-length encodings.
  - FIFO entry field positions: DATA[7:0], PE=8, FE=9, BI=10.
  - The FSM state enum.
- The sub-module uart_8250_baud_tick holds the divisor counter and tick pulse. The transmit path will reuse it.
- FIFO storage stays inline as a register array with head/tail pointers plus one extra wrap bit.

## Test plan
- D=1, 8N1, send 0x55 → DAT_O=0x55, DR_O=1, all error flags 0. After RD_I: DR_O=0, LEVEL_O=0.
- 7E1, send 0x2A with a deliberately wrong parity bit → DAT_O=0x2A, PE_O=1, ERR_O=1. After a pop: ERR_O=0.
- 8N1, send 0xA5 with stop=0 → FE_O=1. Hold RX low for 2 frames → one 0x00 entry with BI_O=1, FE_O=1, and no further push until RX returns high.
- Send 17 characters 0x00–0x10 with no reads (depth 16) → LEVEL_O=16, OE_O=1, pops return 0x00–0x0F. LSR_CLR_I clears OE_O.
- A low glitch of OVERSAMPLE/4 ticks on idle RX_I → no push, FSM back in IDLE.
- 8N1, one character left unread → TIMEOUT_O asserts after 640 ticks and clears on RD_I. FIFO_CLR_I mid-frame → the FIFO empties and the frame in progress still lands as entry 0.

Source files
------------

// File: rtl/uart_8250_pkg.sv
// Shared definitions for the 8250 receive path: LCR fields, word lengths, FIFO entry layout, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_8250_pkg;

  // LCR field indices
  localparam int LCR_WLS_LSB = 0;
  localparam int LCR_WLS_MSB = 1;
  localparam int LCR_STB     = 2;
  localparam int LCR_PEN     = 3;
  localparam int LCR_EPS     = 4;

  // Word-length encodings
  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;

  // Receive FIFO entry layout
  localparam int ENT_DATA_MSB = 7;
  localparam int ENT_PE       = 8;
  localparam int ENT_FE       = 9;
  localparam int ENT_BI       = 10;
  localparam int ENT_W        = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK_WAIT
  } rx_state_t;

  // Index of the last data bit for a given word length
  function automatic logic [2:0] last_bit_idx(input logic [1:0] wls);
    logic [2:0] idx;
    case (wls)
      WLS_5:   idx = 3'd4;
      WLS_6:   idx = 3'd5;
      WLS_7:   idx = 3'd6;
      WLS_8:   idx = 3'd7;
      default: idx = 3'd7;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/uart_8250_baud_tick.sv
// Baud tick generator: one-cycle pulse every max(DIVISOR_I,1) CLK_I cycles.
// Latency: divisor changes take effect at the next counter reload.
// Backpressure: none; free-running.
module uart_8250_baud_tick (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic [15:0] DIVISOR_I,
  output logic        TICK_O
);

  logic [15:0] cnt;
  logic [15:0] reload;

  // A divisor of 0 behaves like 1: reload to 0 so every cycle ticks
  assign reload = (DIVISOR_I == 16'd0) ? 16'd0 : (DIVISOR_I - 16'd1);
  assign TICK_O = (cnt == 16'd0);

  // Down-counter; the divisor is only looked at when reloading
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      cnt <= 16'd0;
    end else if (TICK_O) begin
      cnt <= reload;
    end else begin
      cnt <= cnt - 16'd1;
    end
  end

endmodule

// File: rtl/uart_8250_rx.sv
// 8250 receive path: oversampling framer with parity/framing/break detection feeding an error-tagged FIFO.
// Latency: push registered the cycle after the stop-sample tick; DR_O/DAT_O/LEVEL_O follow one edge later.
// Backpressure: none toward the line; a push into a full FIFO is dropped and flagged on OE_O.
module uart_8250_rx
  import uart_8250_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = 16
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        RX_I,
  input  logic [15:0] DIVISOR_I,
  input  logic [4:0]  LCR_I,
  input  logic        RD_I,
  input  logic        FIFO_CLR_I,
  input  logic        LSR_CLR_I,
  output logic [7:0]  DAT_O,
  output logic        DR_O,
  output logic        OE_O,
  output logic        PE_O,
  output logic        FE_O,
  output logic        BI_O,
  output logic        ERR_O,
  output logic        TIMEOUT_O,
  output logic [6:0]  LEVEL_O
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int OS_W = $clog2(OVERSAMPLE);

  logic tick;
  logic rx_meta, rx_s;

  rx_state_t state, state_nxt;
  logic [OS_W-1:0] os_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      data_sr;
  logic [1:0]      wls_q;
  logic            pen_q, eps_q;
  logic            par_bit;
  logic            all_zero;
  logic            half_end, full_end, os_wrap, brk, pe_calc;
  logic            push_vld;
  logic [ENT_W-1:0] push_dat;

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, level;
  logic [AW:0]      err_cnt;
  logic [ENT_W-1:0] head;
  logic             empty, full, do_push, do_pop, overrun;
  logic             push_err, pop_err;

  logic [3:0]  frame_bits;
  logic [19:0] to_lim, to_cnt;
  logic        unused_stb;

  // Stop-bit count is not checked; only one stop bit is sampled
  assign unused_stb = LCR_I[LCR_STB];

  uart_8250_baud_tick u_tick (
    .CLK_I     (CLK_I),
    .RST_I     (RST_I),
    .DIVISOR_I (DIVISOR_I),
    .TICK_O    (tick)
  );

  // Two-flop synchronizer on the serial line, idling high
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= RX_I;
      rx_s    <= rx_meta;
    end
  end

  assign half_end = tick && (os_cnt == OS_W'(OVERSAMPLE / 2 - 1));
  assign full_end = tick && (os_cnt == OS_W'(OVERSAMPLE - 1));
  assign os_wrap  = (state == ST_START) ? half_end : full_end;
  assign brk      = all_zero && !rx_s;
  assign pe_calc  = pen_q && (par_bit != (^data_sr ^ ~eps_q));

  // FSM state register
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state: start detect, mid-bit sampling, break hold-off
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:     if (tick && !rx_s) state_nxt = ST_START;
      ST_START:    if (half_end) state_nxt = rx_s ? ST_IDLE : ST_DATA;
      ST_DATA:     if (full_end && (bit_cnt == last_bit_idx(wls_q)))
                     state_nxt = pen_q ? ST_PARITY : ST_STOP;
      ST_PARITY:   if (full_end) state_nxt = ST_STOP;
      ST_STOP:     if (full_end) state_nxt = brk ? ST_BRK_WAIT : ST_IDLE;
      ST_BRK_WAIT: if (rx_s) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // Frame datapath: oversample counter, bit shifting, error capture, push request
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      os_cnt   <= '0;
      bit_cnt  <= 3'd0;
      data_sr  <= 8'd0;
      wls_q    <= WLS_5;
      pen_q    <= 1'b0;
      eps_q    <= 1'b0;
      par_bit  <= 1'b0;
      all_zero <= 1'b0;
      push_vld <= 1'b0;
      push_dat <= '0;
    end else begin
      push_vld <= 1'b0;
      if ((state == ST_IDLE) || (state == ST_BRK_WAIT)) os_cnt <= '0;
      else if (tick) os_cnt <= os_wrap ? '0 : os_cnt + 1'b1;
      case (state)
        ST_START: if (half_end && !rx_s) begin
          // Line control is frozen for the whole frame here
          wls_q    <= LCR_I[LCR_WLS_MSB:LCR_WLS_LSB];
          pen_q    <= LCR_I[LCR_PEN];
          eps_q    <= LCR_I[LCR_EPS];
          data_sr  <= 8'd0;
          bit_cnt  <= 3'd0;
          all_zero <= 1'b1;
        end
        ST_DATA: if (full_end) begin
          data_sr[bit_cnt] <= rx_s;
          all_zero         <= all_zero && !rx_s;
          bit_cnt          <= bit_cnt + 3'd1;
        end
        ST_PARITY: if (full_end) begin
          par_bit  <= rx_s;
          all_zero <= all_zero && !rx_s;
        end
        ST_STOP: if (full_end) begin
          push_vld                    <= 1'b1;
          push_dat[ENT_BI]            <= brk;
          push_dat[ENT_FE]            <= !rx_s;
          push_dat[ENT_PE]            <= pe_calc;
          push_dat[ENT_DATA_MSB:0]    <= brk ? 8'd0 : data_sr;
        end
        default: ;
      endcase
    end
  end

  assign level    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (level == (AW + 1)'(FIFO_DEPTH));
  assign head     = mem[rd_ptr[AW-1:0]];
  assign do_pop   = RD_I && !empty && !FIFO_CLR_I;
  assign do_push  = push_vld && !FIFO_CLR_I && (!full || do_pop);
  assign overrun  = push_vld && !FIFO_CLR_I && full && !do_pop;
  assign push_err = |push_dat[ENT_BI:ENT_PE];
  assign pop_err  = |head[ENT_BI:ENT_PE];

  // FIFO storage; no reset needed, occupancy is tracked by the pointers
  always_ff @(posedge CLK_I) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  // FIFO pointers, errored-entry count and sticky overrun
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      err_cnt <= '0;
      OE_O    <= 1'b0;
    end else begin
      if (FIFO_CLR_I) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        err_cnt <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + 1'b1;
        if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        err_cnt <= err_cnt + (AW + 1)'(do_push && push_err) - (AW + 1)'(do_pop && pop_err);
      end
      if (overrun)        OE_O <= 1'b1;
      else if (LSR_CLR_I) OE_O <= 1'b0;
    end
  end

  assign DR_O    = !empty;
  assign DAT_O   = empty ? 8'd0 : head[ENT_DATA_MSB:0];
  assign PE_O    = !empty && head[ENT_PE];
  assign FE_O    = !empty && head[ENT_FE];
  assign BI_O    = !empty && head[ENT_BI];
  assign ERR_O   = (err_cnt != '0);
  assign LEVEL_O = 7'(level);

  // Timeout window is four character times at the current line setting
  assign frame_bits = 4'd3 + {1'b0, last_bit_idx(LCR_I[LCR_WLS_MSB:LCR_WLS_LSB])} + {3'd0, LCR_I[LCR_PEN]};
  assign to_lim     = {16'd0, frame_bits} * 20'(4 * OVERSAMPLE);

  // Character timeout: count ticks while data waits with no FIFO activity
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      to_cnt    <= 20'd0;
      TIMEOUT_O <= 1'b0;
    end else if (FIFO_CLR_I || do_push || do_pop || empty) begin
      to_cnt    <= 20'd0;
      TIMEOUT_O <= 1'b0;
    end else if (tick && !TIMEOUT_O) begin
      to_cnt <= to_cnt + 20'd1;
      if (to_cnt + 20'd1 >= to_lim) TIMEOUT_O <= 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_8250_rx.sv
// Directed bench for uart_8250_rx at divisor 1, 16x oversampling, 16-deep FIFO.
// Latency: frames are driven bit-by-bit; outputs sampled on the falling edge.
// Backpressure: n/a.
module tb_uart_8250_rx;

  localparam int OS = 16;

  logic        CLK_I = 1'b0;
  logic        RST_I;
  logic        RX_I;
  logic [15:0] DIVISOR_I;
  logic [4:0]  LCR_I;
  logic        RD_I, FIFO_CLR_I, LSR_CLR_I;
  logic [7:0]  DAT_O;
  logic        DR_O, OE_O, PE_O, FE_O, BI_O, ERR_O, TIMEOUT_O;
  logic [6:0]  LEVEL_O;

  int n_vec = 0;
  int n_err = 0;

  uart_8250_rx #(.FIFO_DEPTH(16), .OVERSAMPLE(OS)) dut (
    .CLK_I      (CLK_I),
    .RST_I      (RST_I),
    .RX_I       (RX_I),
    .DIVISOR_I  (DIVISOR_I),
    .LCR_I      (LCR_I),
    .RD_I       (RD_I),
    .FIFO_CLR_I (FIFO_CLR_I),
    .LSR_CLR_I  (LSR_CLR_I),
    .DAT_O      (DAT_O),
    .DR_O       (DR_O),
    .OE_O       (OE_O),
    .PE_O       (PE_O),
    .FE_O       (FE_O),
    .BI_O       (BI_O),
    .ERR_O      (ERR_O),
    .TIMEOUT_O  (TIMEOUT_O),
    .LEVEL_O    (LEVEL_O)
  );

  always #5 CLK_I = ~CLK_I;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK_I);
  endtask

  // Start bit, nb data bits LSB first, optional parity, stop, one idle bit
  task automatic send(input logic [7:0] d, input int nb, input bit pen, input bit par, input bit stp);
    RX_I = 1'b0; cyc(OS);
    for (int i = 0; i < nb; i++) begin
      RX_I = d[i]; cyc(OS);
    end
    if (pen) begin
      RX_I = par; cyc(OS);
    end
    RX_I = stp; cyc(OS);
    RX_I = 1'b1; cyc(OS);
  endtask

  task automatic pop();
    RD_I = 1'b1; cyc(1);
    RD_I = 1'b0;
  endtask

  initial begin
    RST_I = 1'b0; RX_I = 1'b1; DIVISOR_I = 16'd1; LCR_I = 5'b00011;
    RD_I = 1'b0; FIFO_CLR_I = 1'b0; LSR_CLR_I = 1'b0;
    cyc(4);
    chk("rst_dat", DAT_O, 8'h00);
    chk("rst_dr", DR_O, 1'b0);
    chk("rst_flags", {OE_O, PE_O, FE_O, BI_O, ERR_O, TIMEOUT_O}, 6'b0);
    chk("rst_level", LEVEL_O, 7'd0);
    RST_I = 1'b1; cyc(4);

    // 8N1 0x55
    send(8'h55, 8, 1'b0, 1'b0, 1'b1);
    chk("c55_dat", DAT_O, 8'h55);
    chk("c55_dr", DR_O, 1'b1);
    chk("c55_err", {PE_O, FE_O, BI_O, ERR_O, OE_O}, 5'b0);
    chk("c55_lvl", LEVEL_O, 7'd1);
    pop();
    chk("c55_pop_dr", DR_O, 1'b0);
    chk("c55_pop_lvl", LEVEL_O, 7'd0);
    chk("c55_pop_dat", DAT_O, 8'h00);

    // 7E1 0x2A: three ones, correct even parity is 1, send 0
    LCR_I = 5'b11010;
    send(8'h2A, 7, 1'b1, 1'b0, 1'b1);
    chk("pe_dat", DAT_O, 8'h2A);
    chk("pe_pe", PE_O, 1'b1);
    chk("pe_fe", FE_O, 1'b0);
    chk("pe_err", ERR_O, 1'b1);
    pop();
    chk("pe_pop_err", ERR_O, 1'b0);
    chk("pe_pop_dr", DR_O, 1'b0);

    // 8N1 0xA5 with stop bit 0
    LCR_I = 5'b00011;
    send(8'hA5, 8, 1'b0, 1'b0, 1'b0);
    chk("fe_dat", DAT_O, 8'hA5);
    chk("fe_flags", {BI_O, FE_O, PE_O}, 3'b010);
    chk("fe_lvl", LEVEL_O, 7'd1);
    pop();

    // Break: line low for two character times
    RX_I = 1'b0; cyc(2 * 10 * OS);
    chk("brk_lvl_low", LEVEL_O, 7'd1);
    chk("brk_flags", {BI_O, FE_O, PE_O}, 3'b110);
    chk("brk_dat", DAT_O, 8'h00);
    RX_I = 1'b1; cyc(3 * OS);
    chk("brk_lvl_rel", LEVEL_O, 7'd1);
    chk("brk_err", ERR_O, 1'b1);
    pop();
    chk("brk_pop_err", ERR_O, 1'b0);

    // Overrun: 17 characters into a 16-deep FIFO
    for (int i = 0; i < 17; i++) send(8'(i), 8, 1'b0, 1'b0, 1'b1);
    chk("ovr_lvl", LEVEL_O, 7'd16);
    chk("ovr_oe", OE_O, 1'b1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovr_pop%0d", i), DAT_O, 8'(i));
      pop();
    end
    chk("ovr_empty", DR_O, 1'b0);
    chk("ovr_oe_held", OE_O, 1'b1);
    LSR_CLR_I = 1'b1; cyc(1); LSR_CLR_I = 1'b0;
    chk("ovr_oe_clr", OE_O, 1'b0);

    // Glitch of OS/4 ticks on idle line
    RX_I = 1'b0; cyc(OS / 4);
    RX_I = 1'b1; cyc(3 * OS);
    chk("glitch_lvl", LEVEL_O, 7'd0);
    chk("glitch_state", 32'(dut.state), 32'(uart_8250_pkg::ST_IDLE));

    // Next character must frame normally; then let it time out
    send(8'h3C, 8, 1'b0, 1'b0, 1'b1);
    chk("post_glitch_dat", DAT_O, 8'h3C);
    cyc(600);
    chk("to_early", TIMEOUT_O, 1'b0);
    cyc(40);
    chk("to_set", TIMEOUT_O, 1'b1);
    pop();
    chk("to_clr", TIMEOUT_O, 1'b0);
    chk("to_pop_dr", DR_O, 1'b0);

    // Flush mid-frame: old entry goes, the frame in flight still lands
    send(8'h11, 8, 1'b0, 1'b0, 1'b1);
    chk("clr_pre_lvl", LEVEL_O, 7'd1);
    fork
      send(8'h96, 8, 1'b0, 1'b0, 1'b1);
      begin
        cyc(50);
        FIFO_CLR_I = 1'b1; cyc(1); FIFO_CLR_I = 1'b0;
        chk("clr_empty", LEVEL_O, 7'd0);
      end
    join
    chk("clr_lvl", LEVEL_O, 7'd1);
    chk("clr_dat", DAT_O, 8'h96);
    pop();
    chk("clr_pop_dr", DR_O, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
